// File: rtl/count_pkg.sv
// Shared types and 7-segment decode for the BCD up/down counter.
// Segment codes are active-low, bit order gfedcba.
package count_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam bcd_t BCD_MAX   = 4'd9;
    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t SEG_TABLE [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic seg_t seg7(input bcd_t d);
        if (d <= BCD_MAX) return SEG_TABLE[d];
        return SEG_BLANK;
    endfunction

    function automatic bcd_t bcd_clamp(input bcd_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control and display bundle for the BCD counter; master drives controls,
// slave (the counter) returns count, segments and pulses.
interface bcd_updown_counter_if
    import count_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    logic                          en;
    logic                          up;
    logic                          sat;
    logic                          load;
    logic [4*NUM_DIGITS-1:0]       load_val;
    logic [4*NUM_DIGITS-1:0]       digits;
    seg_t [NUM_DIGITS-1:0]         hex;
    logic                          tick;
    logic                          wrap;

    modport master (
        output en, up, sat, load, load_val,
        input  digits, hex, tick, wrap
    );

    modport slave (
        input  en, up, sat, load, load_val,
        output digits, hex, tick, wrap
    );
endinterface

// File: rtl/bcd_updown_counter_seg7_dec.sv
// One BCD digit to active-low 7-segment pattern; non-decimal codes blank.
module seg7_dec
    import count_pkg::*;
(
    input  bcd_t bcd_i,
    output seg_t seg_o
);
    assign seg_o = seg7(bcd_i);
endmodule

// File: rtl/bcd_updown_counter.sv
// Prescaled multi-digit BCD up/down counter with wrap/saturate modes,
// synchronous load and per-digit 7-segment outputs.
module bcd_updown_counter
    import count_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50
)(
    input  logic                  clk,
    input  logic                  rst,
    bcd_updown_counter_if.slave   bus
);
    localparam int            CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] PS_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0]         ps_q, ps_d;
    bcd_t [NUM_DIGITS-1:0] dig_q, dig_d, step_val, load_clamped;
    seg_t [NUM_DIGITS-1:0] hex_w;
    logic                  wrap_q, wrap_d;
    logic                  ps_expire, tick, carry;

    assign ps_expire = bus.en && (ps_q == PS_LAST);
    // Load and reset both steal the step, so the pulse is masked the same way.
    assign tick      = ps_expire && !bus.load && !rst;

    // Ripple carry/borrow: a digit only moves if every lower digit was at its limit.
    // carry left set after the loop means the whole count was at its limit.
    always_comb begin
        step_val = dig_q;
        carry    = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (bus.up) begin
                    if (dig_q[i] >= BCD_MAX) begin
                        step_val[i] = 4'd0;
                    end else begin
                        step_val[i] = dig_q[i] + 4'd1;
                        carry       = 1'b0;
                    end
                end else begin
                    if (dig_q[i] == 4'd0) begin
                        step_val[i] = BCD_MAX;
                    end else begin
                        step_val[i] = dig_q[i] - 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            load_clamped[i] = bcd_clamp(bus.load_val[4*i +: 4]);
        end
    end

    always_comb begin
        dig_d  = dig_q;
        ps_d   = ps_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            dig_d = load_clamped;
            ps_d  = '0;
        end else if (bus.en) begin
            if (ps_expire) begin
                ps_d   = '0;
                wrap_d = carry && !bus.sat;
                if (!(carry && bus.sat)) dig_d = step_val;
            end else begin
                ps_d = ps_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dig_q  <= '0;
            ps_q   <= '0;
            wrap_q <= 1'b0;
        end else begin
            dig_q  <= dig_d;
            ps_q   <= ps_d;
            wrap_q <= wrap_d;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
        seg7_dec u_seg (
            .bcd_i (dig_q[g]),
            .seg_o (hex_w[g])
        );
    end

    assign bus.digits = dig_q;
    assign bus.hex    = hex_w;
    assign bus.tick   = tick;
    assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench: 4-digit /50 counter for the main behaviour, plus a
// 2-digit /1 instance for the every-cycle-tick wrap case.
module tb_bcd_updown_counter;
    import count_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   tick_a = 0, wrap_a = 0, wrap_b = 0;
    int   t0, w0;

    always #5 clk = ~clk;

    bcd_updown_counter_if #(.NUM_DIGITS(4)) a_if ();
    bcd_updown_counter_if #(.NUM_DIGITS(2)) b_if ();

    bcd_updown_counter #(.NUM_DIGITS(4), .TICK_DIV(50)) dut_a (
        .clk (clk), .rst (rst), .bus (a_if)
    );
    bcd_updown_counter #(.NUM_DIGITS(2), .TICK_DIV(1)) dut_b (
        .clk (clk), .rst (rst), .bus (b_if)
    );

    always @(posedge clk) begin
        if (a_if.tick) tick_a <= tick_a + 1;
        if (a_if.wrap) wrap_a <= wrap_a + 1;
        if (b_if.wrap) wrap_b <= wrap_b + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic u, input logic s);
        a_if.load = 1'b1; a_if.load_val = v; a_if.up = u; a_if.sat = s;
        step(1);
        a_if.load = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_if.en = 1'b0; a_if.up = 1'b1; a_if.sat = 1'b0; a_if.load = 1'b0; a_if.load_val = '0;
        b_if.en = 1'b0; b_if.up = 1'b1; b_if.sat = 1'b0; b_if.load = 1'b0; b_if.load_val = '0;
        step(2);
        chk("rst_digits", 32'(a_if.digits), 32'h0000);
        chk("rst_hex",    32'(a_if.hex), 32'({4{7'h40}}));
        chk("rst_tick",   32'(a_if.tick), 32'h0);
        chk("rst_wrap",   32'(a_if.wrap), 32'h0);

        // count up twelve steps from reset
        rst = 1'b0; a_if.en = 1'b1; a_if.up = 1'b1;
        t0 = tick_a;
        step(600);
        chk("up12_digits", 32'(a_if.digits), 32'h0012);
        chk("up12_ticks",  32'(tick_a - t0), 32'd12);
        chk("up12_hex0",   32'(a_if.hex[0]), 32'h24);
        chk("up12_hex1",   32'(a_if.hex[1]), 32'h79);
        chk("up12_hex2",   32'(a_if.hex[2]), 32'h40);
        chk("up12_tick_lo", 32'(a_if.tick), 32'h0);
        step(49);
        chk("tick_at_last", 32'(a_if.tick), 32'h1);
        chk("hold_before_step", 32'(a_if.digits), 32'h0012);
        step(1);
        chk("step_13", 32'(a_if.digits), 32'h0013);

        // enable gating freezes the prescaler mid-way
        step(20);
        a_if.en = 1'b0; t0 = tick_a;
        step(200);
        chk("en0_digits", 32'(a_if.digits), 32'h0013);
        chk("en0_ticks",  32'(tick_a - t0), 32'd0);
        a_if.en = 1'b1;
        step(29);
        chk("reen_tick", 32'(a_if.tick), 32'h1);
        step(1);
        chk("reen_step", 32'(a_if.digits), 32'h0014);

        // direction is only looked at on the tick cycle
        a_if.up = 1'b0;
        step(20);
        a_if.up = 1'b1;
        step(30);
        chk("dir_sampled", 32'(a_if.digits), 32'h0015);

        // clamped load restarts the prescaler
        do_load(16'h0A3F, 1'b1, 1'b0);
        chk("load_clamp", 32'(a_if.digits), 32'h0939);
        chk("load_hex0",  32'(a_if.hex[0]), 32'h10);
        step(49);
        chk("load_tick49", 32'(a_if.tick), 32'h1);
        chk("load_hold",   32'(a_if.digits), 32'h0939);
        step(1);
        chk("load_step", 32'(a_if.digits), 32'h0940);

        // load on the expiry cycle masks the tick
        step(49);
        w0 = wrap_a;
        a_if.load = 1'b1; a_if.load_val = 16'h9998; a_if.sat = 1'b0; a_if.up = 1'b1;
        #1;
        chk("load_masks_tick", 32'(a_if.tick), 32'h0);
        step(1);
        a_if.load = 1'b0;
        chk("load_9998", 32'(a_if.digits), 32'h9998);
        step(50);
        chk("up_9999", 32'(a_if.digits), 32'h9999);
        chk("up_9999_wrap", 32'(a_if.wrap), 32'h0);
        step(50);
        chk("wrap_0000", 32'(a_if.digits), 32'h0000);
        chk("wrap_pulse", 32'(a_if.wrap), 32'h1);
        step(1);
        chk("wrap_drop", 32'(a_if.wrap), 32'h0);
        chk("wrap_count", 32'(wrap_a - w0), 32'd1);

        // saturate going down
        w0 = wrap_a;
        do_load(16'h0001, 1'b0, 1'b1);
        step(50);
        chk("sat_dn1", 32'(a_if.digits), 32'h0000);
        step(50);
        chk("sat_dn2", 32'(a_if.digits), 32'h0000);
        step(50);
        chk("sat_dn3", 32'(a_if.digits), 32'h0000);
        chk("sat_dn_nowrap", 32'(wrap_a - w0), 32'd0);

        // saturate going up
        do_load(16'h9999, 1'b1, 1'b1);
        step(51);
        chk("sat_up", 32'(a_if.digits), 32'h9999);
        chk("sat_up_nowrap", 32'(wrap_a - w0), 32'd0);

        // wrap going down
        do_load(16'h0000, 1'b0, 1'b0);
        step(50);
        chk("wrap_dn", 32'(a_if.digits), 32'h9999);
        chk("wrap_dn_pulse", 32'(a_if.wrap), 32'h1);

        // reset beats load and tick
        a_if.up = 1'b1;
        step(49);
        chk("pre_rst_tick", 32'(a_if.tick), 32'h1);
        rst = 1'b1; a_if.load = 1'b1; a_if.load_val = 16'h1234;
        #1;
        chk("rst_masks_tick", 32'(a_if.tick), 32'h0);
        step(1);
        chk("rst_ld_digits", 32'(a_if.digits), 32'h0000);
        chk("rst_ld_wrap",   32'(a_if.wrap), 32'h0);
        rst = 1'b0; a_if.load = 1'b0;
        step(49);
        chk("post_rst_tick", 32'(a_if.tick), 32'h1);
        chk("post_rst_hold", 32'(a_if.digits), 32'h0000);
        step(1);
        chk("post_rst_step", 32'(a_if.digits), 32'h0001);

        // TICK_DIV=1: every enabled cycle is a step
        b_if.en = 1'b1; b_if.up = 1'b1; b_if.sat = 1'b0;
        w0 = wrap_b;
        #1;
        chk("b_tick_always", 32'(b_if.tick), 32'h1);
        step(50);
        chk("b_50", 32'(b_if.digits), 32'h50);
        step(50);
        chk("b_100", 32'(b_if.digits), 32'h00);
        chk("b_wrap_pulse", 32'(b_if.wrap), 32'h1);
        b_if.en = 1'b0;
        step(1);
        chk("b_wrap_once", 32'(wrap_b - w0), 32'd1);
        chk("b_wrap_drop", 32'(b_if.wrap), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
